// File: rtl/sound_wave_arbiter.sv
// Channel-3 wave RAM owner: arbitrates CPU bus access against sample fetches.
// Define SOUND_WAVE_CGB_ACCESS_EN for CGB behaviour: no access window applies while channel 3 plays.
module sound_wave_arbiter #(
  parameter int unsigned WINDOW = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] cpu_addr,
  input  logic       cpu_rd,
  input  logic       cpu_wr,
  input  logic [7:0] cpu_din,
  output logic [7:0] cpu_dout,
  output logic       cpu_rd_valid,
  input  logic       ch3_on,
  input  logic       fetch_req,
  input  logic [3:0] fetch_addr,
  output logic [7:0] fetch_data,
  output logic       fetch_valid,
  output logic       wb_pending,
  output logic [3:0] last_addr
);

  localparam int unsigned AW    = 4;
  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 16;

  // One-hot owner of the single RAM write port in the current cycle
  typedef enum logic [2:0] {
    IDLE   = 3'b001,
    FETCH  = 3'b010,
    COMMIT = 3'b100
  } owner_t;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_data;

  owner_t        owner;
  logic          perm;
  logic          accept;
  logic          cpu_read;
  logic [AW-1:0] ea;
  logic          ram_we;
  logic [AW-1:0] ram_waddr;
  logic [DW-1:0] ram_wdata;
  logic          buf_load;
  logic          pend_next;
  logic [DW-1:0] fetch_byte;
  logic [DW-1:0] cpu_byte;

`ifdef SOUND_WAVE_CGB_ACCESS_EN
  assign perm = 1'b1;
`else
  localparam int unsigned CW = 4;
  logic [CW-1:0] window_cnt;

  assign perm = !ch3_on || (window_cnt != '0);

  // Access window reopens on every fetch and collapses when playback stops
  always_ff @(posedge clk) begin
    if (rst || !ch3_on) begin
      window_cnt <= '0;
    end else if (fetch_req) begin
      window_cnt <= CW'(WINDOW);
    end else if (window_cnt != '0) begin
      window_cnt <= window_cnt - CW'(1);
    end
  end
`endif

  // While playing, the CPU only sees the byte the fetcher last touched
  assign ea       = ch3_on ? last_addr : cpu_addr;
  assign accept   = cpu_wr && perm;
  assign cpu_read = cpu_rd && !cpu_wr;

  // Reads see the buffered write as if it were already in RAM
  assign fetch_byte = (wb_pending && (wb_addr == fetch_addr)) ? wb_data : mem[fetch_addr];
  assign cpu_byte   = (wb_pending && (wb_addr == ea))         ? wb_data : mem[ea];

  always_comb begin
    owner     = IDLE;
    ram_we    = 1'b0;
    ram_waddr = wb_addr;
    ram_wdata = wb_data;
    buf_load  = 1'b0;
    pend_next = wb_pending;

    if (fetch_req) begin
      owner = FETCH;
    end else if (wb_pending) begin
      owner = COMMIT;
    end

    case (owner)
      FETCH: begin
        // Port is blocked; a new write replaces any buffered one
        if (accept) begin
          buf_load  = 1'b1;
          pend_next = 1'b1;
        end
      end
      COMMIT: begin
        ram_we    = 1'b1;
        buf_load  = accept;
        pend_next = accept;
      end
      default: begin
        if (accept) begin
          ram_we    = 1'b1;
          ram_waddr = ea;
          ram_wdata = cpu_din;
        end
      end
    endcase
  end

  // RAM contents survive reset; a reset cycle never commits
  always_ff @(posedge clk) begin
    if (!rst && ram_we) begin
      mem[ram_waddr] <= ram_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cpu_dout     <= 8'hFF;
      cpu_rd_valid <= 1'b0;
      fetch_data   <= '0;
      fetch_valid  <= 1'b0;
      wb_pending   <= 1'b0;
      last_addr    <= '0;
      wb_addr      <= '0;
      wb_data      <= '0;
    end else begin
      wb_pending   <= pend_next;
      fetch_valid  <= fetch_req;
      cpu_rd_valid <= cpu_read;
      if (buf_load) begin
        wb_addr <= ea;
        wb_data <= cpu_din;
      end
      if (fetch_req) begin
        fetch_data <= fetch_byte;
        last_addr  <= fetch_addr;
      end
      if (cpu_read) begin
        cpu_dout <= perm ? cpu_byte : 8'hFF;
      end
    end
  end

endmodule

// File: tb/tb_sound_wave_arbiter.sv
// Directed bench for sound_wave_arbiter: access rules, fetch, write buffer and reset.
module tb_sound_wave_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] cpu_addr;
  logic       cpu_rd;
  logic       cpu_wr;
  logic [7:0] cpu_din;
  logic [7:0] cpu_dout;
  logic       cpu_rd_valid;
  logic       ch3_on;
  logic       fetch_req;
  logic [3:0] fetch_addr;
  logic [7:0] fetch_data;
  logic       fetch_valid;
  logic       wb_pending;
  logic [3:0] last_addr;

  int checks = 0;
  int errors = 0;

  sound_wave_arbiter #(.WINDOW(2)) dut (
    .clk(clk), .rst(rst),
    .cpu_addr(cpu_addr), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_din(cpu_din),
    .cpu_dout(cpu_dout), .cpu_rd_valid(cpu_rd_valid),
    .ch3_on(ch3_on), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_data(fetch_data), .fetch_valid(fetch_valid),
    .wb_pending(wb_pending), .last_addr(last_addr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_strobes();
    cpu_rd    = 1'b0;
    cpu_wr    = 1'b0;
    fetch_req = 1'b0;
  endtask

  task automatic cpu_write(input logic [3:0] a, input logic [7:0] d);
    cpu_addr = a; cpu_din = d; cpu_wr = 1'b1;
    tick();
    clear_strobes();
  endtask

  task automatic cpu_read(input logic [3:0] a);
    cpu_addr = a; cpu_rd = 1'b1;
    tick();
    clear_strobes();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    checks++; if (cpu_dout !== 8'hFF) begin errors++; $display("FAIL reset_dout got %h want ff", cpu_dout); end
    checks++; if (cpu_rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid got %b want 0", cpu_rd_valid); end
    checks++; if (fetch_data !== 8'h00) begin errors++; $display("FAIL reset_fetch_data got %h want 00", fetch_data); end
    checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL reset_fetch_valid got %b want 0", fetch_valid); end
    checks++; if (wb_pending !== 1'b0) begin errors++; $display("FAIL reset_wb_pending got %b want 0", wb_pending); end
    checks++; if (last_addr !== 4'h0) begin errors++; $display("FAIL reset_last_addr got %h want 0", last_addr); end
    rst = 1'b0;
  endtask

  task automatic test_basic_rw();
    cpu_write(4'd3, 8'hA5);
    checks++; if (cpu_rd_valid !== 1'b0) begin errors++; $display("FAIL wr_no_rd_valid got %b want 0", cpu_rd_valid); end
    cpu_read(4'd3);
    checks++; if (cpu_rd_valid !== 1'b1) begin errors++; $display("FAIL rd_valid got %b want 1", cpu_rd_valid); end
    checks++; if (cpu_dout !== 8'hA5) begin errors++; $display("FAIL rd_data got %h want a5", cpu_dout); end
    tick();
    checks++; if (cpu_rd_valid !== 1'b0) begin errors++; $display("FAIL rd_valid_pulse got %b want 0", cpu_rd_valid); end
    // Simultaneous read and write acts as a write only
    cpu_addr = 4'd1; cpu_din = 8'h5C; cpu_rd = 1'b1; cpu_wr = 1'b1;
    tick();
    clear_strobes();
    checks++; if (cpu_rd_valid !== 1'b0) begin errors++; $display("FAIL rdwr_no_valid got %b want 0", cpu_rd_valid); end
    cpu_read(4'd1);
    checks++; if (cpu_dout !== 8'h5C) begin errors++; $display("FAIL rdwr_written got %h want 5c", cpu_dout); end
  endtask

  task automatic test_fetch();
    cpu_write(4'd7, 8'h3C);
    fetch_req = 1'b1; fetch_addr = 4'd7;
    tick();
    clear_strobes();
    checks++; if (fetch_valid !== 1'b1) begin errors++; $display("FAIL fetch_valid got %b want 1", fetch_valid); end
    checks++; if (fetch_data !== 8'h3C) begin errors++; $display("FAIL fetch_data got %h want 3c", fetch_data); end
    checks++; if (last_addr !== 4'd7) begin errors++; $display("FAIL fetch_last_addr got %h want 7", last_addr); end
    tick();
    checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL fetch_valid_pulse got %b want 0", fetch_valid); end
  endtask

  task automatic test_collide();
    cpu_write(4'd9, 8'h99);
    cpu_write(4'd2, 8'h22);
    fetch_req = 1'b1; fetch_addr = 4'd9;
    cpu_addr = 4'd2; cpu_din = 8'h11; cpu_wr = 1'b1;
    tick();
    clear_strobes();
    checks++; if (wb_pending !== 1'b1) begin errors++; $display("FAIL collide_pending got %b want 1", wb_pending); end
    checks++; if (fetch_data !== 8'h99) begin errors++; $display("FAIL collide_fetch got %h want 99", fetch_data); end
    cpu_read(4'd2);
    checks++; if (cpu_dout !== 8'h11) begin errors++; $display("FAIL collide_forward got %h want 11", cpu_dout); end
    checks++; if (wb_pending !== 1'b0) begin errors++; $display("FAIL collide_cleared got %b want 0", wb_pending); end
    cpu_read(4'd2);
    checks++; if (cpu_dout !== 8'h11) begin errors++; $display("FAIL collide_committed got %h want 11", cpu_dout); end
  endtask

  task automatic test_window();
    cpu_write(4'd5, 8'h77);
    cpu_write(4'd0, 8'h0A);
    ch3_on = 1'b1;
    fetch_req = 1'b1; fetch_addr = 4'd5;
    tick();
    clear_strobes();
    checks++; if (fetch_data !== 8'h77) begin errors++; $display("FAIL win_fetch got %h want 77", fetch_data); end
    cpu_read(4'd0);
    checks++; if (cpu_dout !== 8'h77) begin errors++; $display("FAIL win_open_read got %h want 77", cpu_dout); end
    tick();
    cpu_read(4'd0);
    checks++; if (cpu_rd_valid !== 1'b1) begin errors++; $display("FAIL win_closed_valid got %b want 1", cpu_rd_valid); end
    checks++; if (cpu_dout !== 8'hFF) begin errors++; $display("FAIL win_closed_read got %h want ff", cpu_dout); end
    cpu_write(4'd0, 8'hEE);
    checks++; if (wb_pending !== 1'b0) begin errors++; $display("FAIL win_drop_pending got %b want 0", wb_pending); end
    ch3_on = 1'b0;
    cpu_read(4'd5);
    checks++; if (cpu_dout !== 8'h77) begin errors++; $display("FAIL win_drop_ram5 got %h want 77", cpu_dout); end
    cpu_read(4'd0);
    checks++; if (cpu_dout !== 8'h0A) begin errors++; $display("FAIL win_drop_ram0 got %h want 0a", cpu_dout); end
  endtask

  task automatic test_back_to_back();
    cpu_write(4'd4, 8'h40);
    cpu_write(4'd6, 8'h60);
    cpu_write(4'd1, 8'hB1);
    fetch_req = 1'b1; fetch_addr = 4'd1; cpu_addr = 4'd4; cpu_din = 8'h01; cpu_wr = 1'b1;
    tick();
    checks++; if (wb_pending !== 1'b1) begin errors++; $display("FAIL b2b_pending1 got %b want 1", wb_pending); end
    fetch_addr = 4'd4; cpu_addr = 4'd6; cpu_din = 8'h02; cpu_wr = 1'b1;
    tick();
    checks++; if (fetch_data !== 8'h01) begin errors++; $display("FAIL b2b_fetch_fwd got %h want 01", fetch_data); end
    cpu_wr = 1'b0; fetch_addr = 4'd6;
    tick();
    clear_strobes();
    checks++; if (fetch_data !== 8'h02) begin errors++; $display("FAIL b2b_fetch_fwd2 got %h want 02", fetch_data); end
    checks++; if (wb_pending !== 1'b1) begin errors++; $display("FAIL b2b_pending3 got %b want 1", wb_pending); end
    cpu_read(4'd6);
    checks++; if (cpu_dout !== 8'h02) begin errors++; $display("FAIL b2b_commit_fwd got %h want 02", cpu_dout); end
    checks++; if (wb_pending !== 1'b0) begin errors++; $display("FAIL b2b_cleared got %b want 0", wb_pending); end
    cpu_read(4'd4);
    checks++; if (cpu_dout !== 8'h40) begin errors++; $display("FAIL b2b_overwritten got %h want 40", cpu_dout); end
    cpu_read(4'd6);
    checks++; if (cpu_dout !== 8'h02) begin errors++; $display("FAIL b2b_ram6 got %h want 02", cpu_dout); end
  endtask

  task automatic test_reset_pending();
    cpu_write(4'd8, 8'h80);
    cpu_read(4'd8);
    checks++; if (cpu_dout !== 8'h80) begin errors++; $display("FAIL rstp_pre got %h want 80", cpu_dout); end
    fetch_req = 1'b1; fetch_addr = 4'd3; cpu_addr = 4'd8; cpu_din = 8'h5A; cpu_wr = 1'b1;
    tick();
    clear_strobes();
    checks++; if (wb_pending !== 1'b1) begin errors++; $display("FAIL rstp_pending got %b want 1", wb_pending); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (wb_pending !== 1'b0) begin errors++; $display("FAIL rstp_cleared got %b want 0", wb_pending); end
    checks++; if (cpu_dout !== 8'hFF) begin errors++; $display("FAIL rstp_dout got %h want ff", cpu_dout); end
    tick();
    cpu_read(4'd8);
    checks++; if (cpu_dout !== 8'h80) begin errors++; $display("FAIL rstp_discarded got %h want 80", cpu_dout); end
  endtask

  initial begin
    rst = 1'b0; ch3_on = 1'b0; cpu_addr = '0; cpu_din = '0; fetch_addr = '0;
    clear_strobes();
    #1;
    test_reset();
    test_basic_rw();
    test_fetch();
    test_collide();
    test_window();
    test_back_to_back();
    test_reset_pending();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
